// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
  localparam logic [3:0]  MIN_TENS_MAX = 4'd5;
  localparam logic [3:0]  UNITS_MAX    = 4'd9;
  localparam logic [15:0] BCD_ZERO     = 16'h0000;

endpackage

// File: rtl/sw_time_core_if.sv
// Control pulses and display-side outputs of the stopwatch core.
interface sw_time_core_if;

  logic        start_stop;
  logic        lap;
  logic        clear;
  logic [15:0] live;
  logic [15:0] lap_val;
  logic        lap_sel;
  logic        running;
  logic        wrap;

  modport master (
    output start_stop, lap, clear,
    input  live, lap_val, lap_sel, running, wrap
  );

  modport slave (
    input  start_stop, lap, clear,
    output live, lap_val, lap_sel, running, wrap
  );

endinterface

// File: rtl/sw_time_core_bcd_digit.sv
// One BCD digit counting 0..MAX; carry fires on the increment that rolls it over.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc && (q == MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= carry ? 4'd0 : q + 4'd1;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/sw_time_core.sv
// Stopwatch core: tick prescaler, MM:SS BCD counter and lap capture.
// Lap capture is built only when SW_LAP_EN is defined.
module sw_time_core
  import sw_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  sw_time_core_if.slave      bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  sw_state_t     state;
  logic [PW-1:0] presc;
  logic          running;
  logic          wrap;
  logic          tick;
  logic          digit_clr;
  logic [3:0]    su, st, mu, mt;
  logic          c_su, c_st, c_mu, c_mt;
  logic [15:0]   live;

  assign tick      = (presc == PRESC_LAST) && (state == RUN);
  assign digit_clr = (state == PAUSE) && bus.clear;
  assign live      = {mt, mu, st, su};

  // Run/pause/idle control and prescaler; the pause edge still counts as a RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
      presc   <= {PW{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_stop) begin
            state   <= RUN;
            running <= 1'b1;
            presc   <= {PW{1'b0}};
          end else begin
            state   <= IDLE;
            running <= 1'b0;
            presc   <= {PW{1'b0}};
          end
        end
        RUN: begin
          presc <= tick ? {PW{1'b0}} : presc + PW'(1);
          if (bus.start_stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        PAUSE: begin
          if (bus.clear) begin
            state   <= IDLE;
            running <= 1'b0;
            presc   <= {PW{1'b0}};
          end else if (bus.start_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end else begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          presc   <= {PW{1'b0}};
        end
      endcase
    end
  end

  bcd_digit #(.MAX(UNITS_MAX)) u_sec_units (
    .clk(clk), .rst(rst), .clr(digit_clr), .inc(tick), .q(su), .carry(c_su)
  );
  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(digit_clr), .inc(c_su), .q(st), .carry(c_st)
  );
  bcd_digit #(.MAX(UNITS_MAX)) u_min_units (
    .clk(clk), .rst(rst), .clr(digit_clr), .inc(c_st), .q(mu), .carry(c_mu)
  );
  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .clr(digit_clr), .inc(c_mu), .q(mt), .carry(c_mt)
  );

  // Carry out of the top digit marks the 59:59 -> 00:00 rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= c_mt;
    end
  end

`ifdef SW_LAP_EN
  logic [15:0] lap_val;
  logic        lap_sel;

  // start_stop outranks lap, so a coincident lap is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_val <= BCD_ZERO;
      lap_sel <= 1'b0;
    end else if ((state == PAUSE) && bus.clear) begin
      lap_val <= BCD_ZERO;
      lap_sel <= 1'b0;
    end else if (bus.start_stop) begin
      lap_val <= lap_val;
      lap_sel <= lap_sel;
    end else if (bus.lap && lap_sel && (state != IDLE)) begin
      lap_val <= lap_val;
      lap_sel <= 1'b0;
    end else if (bus.lap && !lap_sel && (state == RUN)) begin
      lap_val <= live;
      lap_sel <= 1'b1;
    end else begin
      lap_val <= lap_val;
      lap_sel <= lap_sel;
    end
  end

  assign bus.lap_val = lap_val;
  assign bus.lap_sel = lap_sel;
`else
  logic unused_lap;
  assign unused_lap  = bus.lap;
  assign bus.lap_val = BCD_ZERO;
  assign bus.lap_sel = 1'b0;
`endif

  assign bus.live    = live;
  assign bus.running = running;
  assign bus.wrap    = wrap;

endmodule

// File: tb/tb_sw_time_core.sv
// Self-checking bench for sw_time_core (TICK_DIV=4): fixed vector table,
// directed corner sequences and random pulses against a run-cycle-count model.
module tb_sw_time_core;

  localparam int TD = 4;
`ifdef SW_LAP_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic clk = 1'b0;
  logic rst;
  sw_time_core_if bus();

  sw_time_core #(.TICK_DIV(TD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: state, number of RUN edges since the count was last zeroed, lap data.
  int          m_st;
  int          n;
  logic [15:0] m_lv;
  logic        m_ls;
  logic        m_wrap;

  function automatic logic [15:0] to_bcd(input int units);
    int m;
    int s;
    m = units / 60;
    s = units % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] m_live();
    return to_bcd((n / TD) % 3600);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit ss, input bit lp, input bit cl, input bit r);
    int units_before;
    bus.start_stop = ss;
    bus.lap        = lp;
    bus.clear      = cl;
    rst            = r;
    m_wrap = 1'b0;
    if (r) begin
      m_st = S_IDLE; n = 0; m_lv = 16'h0000; m_ls = 1'b0;
    end else if (cl && m_st == S_PAUSE) begin
      m_st = S_IDLE; n = 0; m_lv = 16'h0000; m_ls = 1'b0;
    end else begin
      units_before = (n / TD) % 3600;
      if (m_st == S_RUN) begin
        n++;
        if (n % (TD * 3600) == 0) m_wrap = 1'b1;
      end
      if (ss) begin
        m_st = (m_st == S_RUN) ? S_PAUSE : S_RUN;
      end else if (lp && LE) begin
        if (m_ls && m_st != S_IDLE) begin
          m_ls = 1'b0;
        end else if (!m_ls && m_st == S_RUN) begin
          m_lv = to_bcd(units_before);
          m_ls = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clear      = 1'b0;
    rst            = 1'b0;
    check("m_live",    bus.live,            m_live());
    check("m_lap_val", bus.lap_val,         m_lv);
    check("m_lap_sel", 16'(bus.lap_sel),    16'(m_ls));
    check("m_running", 16'(bus.running),    16'(m_st == S_RUN));
    check("m_wrap",    16'(bus.wrap),       16'(m_wrap));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit          ss, lp, cl, r;
    bit          run;
    logic [15:0] live;
    bit          lsel;
    logic [15:0] lval;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clear      = 1'b0;
    rst            = 1'b1;
    m_st = S_IDLE; n = 0; m_lv = 16'h0000; m_ls = 1'b0; m_wrap = 1'b0;

    //          ss    lp    cl    r     run   live      lsel      lval
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0,     16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0,     16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0,     16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0,     16'h0000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0,     16'h0000};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0,     16'h0000};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0,     16'h0000};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0,     16'h0000};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, LE,       LE ? 16'h0001 : 16'h0000};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, LE,       LE ? 16'h0001 : 16'h0000};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0,     LE ? 16'h0001 : 16'h0000};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0,     16'h0000};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0,     16'h0000};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ss, tbl[i].lp, tbl[i].cl, tbl[i].r);
      check("tbl_running", 16'(bus.running), 16'(tbl[i].run));
      check("tbl_live",    bus.live,         tbl[i].live);
      check("tbl_lap_sel", 16'(bus.lap_sel), 16'(tbl[i].lsel));
      check("tbl_lap_val", bus.lap_val,      tbl[i].lval);
    end

    // 0010 after 40 cycles of running
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("start_running", 16'(bus.running), 16'h0001);
    idle(40);
    check("live_40", bus.live, 16'h0010);

    // Rollover 59:59 -> 00:00
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3598 * TD);
    check("pre_5958", bus.live, 16'h5958);
    idle(TD);
    check("pre_5959", bus.live, 16'h5959);
    idle(TD);
    check("wrap_live", bus.live, 16'h0000);
    check("wrap_pulse", 16'(bus.wrap), 16'h0001);
    check("wrap_running", 16'(bus.running), 16'h0001);
    idle(1);
    check("wrap_one_cycle", 16'(bus.wrap), 16'h0000);

    // Lap capture and release while counting
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(12 * TD);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("lap_val_cap", bus.lap_val, LE ? 16'h0012 : 16'h0000);
    check("lap_sel_cap", 16'(bus.lap_sel), 16'(LE));
    idle(5 * TD);
    check("lap_live_runs", bus.live, 16'h0017);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("lap_sel_rel", 16'(bus.lap_sel), 16'h0000);
    check("lap_val_kept", bus.lap_val, LE ? 16'h0012 : 16'h0000);

    // Fractional unit preserved across pause (pause taken with presc at 2)
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(TD + 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);
    check("pause_frozen", bus.live, 16'h0001);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("resume_hold", bus.live, 16'h0001);
    idle(1);
    check("resume_inc", bus.live, 16'h0002);

    // Clear ignored in RUN, honoured in PAUSE; reset mid-run
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clear_run", bus.live, 16'h0002);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clear_pause", bus.live, 16'h0000);
    check("clear_idle", 16'(bus.running), 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3 * TD);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_live", bus.live, 16'h0000);
    check("rst_running", 16'(bus.running), 16'h0000);

    // Random pulses against the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(39) == 0, $urandom_range(15) == 0,
           $urandom_range(29) == 0, $urandom_range(799) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
